maj_result_checker: RTL and testbench
=====================================

Name: maj_result_checker

Overview:
- Hardware self-check stage directly downstream of the 59-input majority gate (`top`).
- Accepts each applied input vector together with the gate's y0 answer over a valid/ready handshake.
- Recomputes the Hamming weight CHUNK bits per cycle, forms the reference majority and flags any disagreement.
- Keeps running vector and error counts and captures the first failing vector for post-run readout.

Parameters:
- N, 59, input vector width (number of majority inputs).
- CHUNK, 8, bits summed per COUNT cycle; 1 <= CHUNK <= N.
- THRESH, (N+1)/2 = 30, reference output is 1 when popcount >= THRESH.
- CNT_W, 32, width of the saturating vector and error counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of counters and first-error capture.
- in_valid  in  1  vector/result pair offered.
- in_ready  out  1  checker can accept; high only in IDLE.
- in_x  in  N  vector applied to the majority gate.
- in_y  in  1  majority gate output y0 for in_x.
- res_valid  out  1  one-cycle pulse, result of one check.
- res_mismatch  out  1  in_y != reference; valid with res_valid.
- res_ref  out  1  reference majority bit.
- res_hw  out  $clog2(N+1)  Hamming weight of the checked vector (6 bits at N=59).
- vec_count  out  CNT_W  vectors checked, saturating.
- err_count  out  CNT_W  mismatches, saturating.
- first_err_valid  out  1  a mismatch has been captured since reset/clr.
- first_err_x  out  N  vector of the first mismatch.
- first_err_y  out  1  in_y of the first mismatch.

Behaviour:
- Reset: FSM=IDLE, in_ready=1, all other outputs and internal registers 0. Reset is asynchronous and active-high.
- K = ceil(N/CHUNK); K=8 at defaults. The last chunk is zero-padded.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_x/in_y, clear the accumulator and chunk index, then go to COUNT. in_valid with in_ready low is ignored; the source must hold data.
- COUNT: in_ready=0. Each cycle add popcount(chunk[idx]) to the accumulator and increment idx. After the K-th chunk, go to CMP.
- CMP: ref = (acc >= THRESH). Drive res_valid=1 for this cycle with res_hw=acc, res_ref=ref and res_mismatch=(in_y!=ref). Return to IDLE.
- Latency: accept edge at cycle 0, res_valid in cycle K+1. Throughput is one vector per K+2 cycles.
- Results have no backpressure; res_* hold their value until the next CMP.
- Counters:
  - vec_count increments in CMP.
  - err_count increments in CMP when mismatch.
  - Both saturate at 2^CNT_W-1 and never wrap.
- First-error capture: on the first mismatch while first_err_valid=0, capture x and y and set first_err_valid. Later mismatches leave the capture unchanged.
- clr coincident with CMP: clr wins. Counters and capture end at 0, but res_valid/res_* still pulse for that vector.
- clr does not disturb the FSM or a check in flight.
- Reset during COUNT/CMP: the check is aborted, no res_valid, counters cleared.
- Accumulator width is $clog2(N+1). Sums never exceed N, so there is no overflow.

Optional Feature:
- Macro: MAJ_CHK_EARLY_EXIT_EN.
- Defined: COUNT exits to CMP as soon as the result is decided, i.e. acc >= THRESH, or acc + remaining_bits < THRESH. remaining_bits is the count of unsummed real (non-pad) bits.
  - res_hw then reports the partial weight.
  - Minimum latency is 2 cycles, and the decision is evaluated after each chunk add.
- Undefined: fixed latency K+1 and exact res_hw. A state/compare-free path is synthesised, with no remaining-bits logic.

Decomposition:
- Shared package maj_chk_pkg:
  - FSM state enum {IDLE, COUNT, CMP}.
  - Functions clog2 and ceil_div.
  - Default constants N_DEF=59, THRESH_DEF=30.
- One natural sub-module: maj_chunk_popcount, a combinational CHUNK-bit popcount returning $clog2(CHUNK+1) bits, instantiated once.

Test Plan:
- x=0, y=0 -> res_valid at cycle 9, res_hw=0, res_ref=0, res_mismatch=0, vec_count=1, err_count=0.
- x with 30 ones (bits 0..29), y=0 -> res_hw=30, res_ref=1, res_mismatch=1, err_count=1, first_err_x=0x3FFFFFFF, first_err_valid=1.
- x with 29 ones, y=0, then all ones (59'h7FF...F), y=0 -> second result res_hw=59, mismatch. err_count=2, first_err_x still the 30-ones vector from the earlier case.
- in_valid held high, 3 vectors back-to-back -> accepts spaced exactly 10 cycles apart, in_ready low 9 cycles each, 3 res_valid pulses.
- clr asserted in the CMP cycle of a mismatching vector -> res_mismatch=1 pulses, vec_count=0, err_count=0, first_err_valid=0. Assert rst in cycle 4 of COUNT -> no res_valid, in_ready=1 immediately.
- With MAJ_CHK_EARLY_EXIT_EN, x=all ones -> res_valid at cycle 5 (30 reached after chunk 4), res_hw=32. x=0 -> exits once remaining bits < 30.

Source files
------------

// File: rtl/maj_chk_pkg.sv
// Shared types, constants and elaboration helpers for the majority result checker.
package maj_chk_pkg;

  localparam int N_DEF      = 59;
  localparam int THRESH_DEF = 30;
  localparam int CHUNK_DEF  = 8;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    CMP   = 2'd2
  } chk_state_e;

  // Ceiling log2, with clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/maj_result_checker_if.sv
// Vector/result handshake bundle between the majority gate harness and the checker.
interface maj_result_checker_if #(
  parameter int N = 59
) ();

  localparam int HW_W = $clog2(N + 1);

  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_x;
  logic            in_y;
  logic            res_valid;
  logic            res_mismatch;
  logic            res_ref;
  logic [HW_W-1:0] res_hw;

  modport master (
    output in_valid, in_x, in_y,
    input  in_ready, res_valid, res_mismatch, res_ref, res_hw
  );

  modport slave (
    input  in_valid, in_x, in_y,
    output in_ready, res_valid, res_mismatch, res_ref, res_hw
  );

endinterface

// File: rtl/maj_chunk_popcount.sv
// Combinational popcount of one CHUNK-bit slice of the vector under check.
module maj_chunk_popcount #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]             chunk,
  output logic [$clog2(CHUNK+1)-1:0]   count
);

  localparam int PC_W = $clog2(CHUNK + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + PC_W'(chunk[i]);
    end
  end

endmodule

// File: rtl/maj_result_checker.sv
// Self-check stage for the majority gate: recomputes the weight chunk by chunk and flags disagreements.
// Define MAJ_CHK_EARLY_EXIT_EN to leave COUNT as soon as the majority decision is settled.
module maj_result_checker
  import maj_chk_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int CHUNK  = CHUNK_DEF,
  parameter int THRESH = (N + 1) / 2,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  maj_result_checker_if.slave  bus,
  output logic [CNT_W-1:0]     vec_count,
  output logic [CNT_W-1:0]     err_count,
  output logic                 first_err_valid,
  output logic [N-1:0]         first_err_x,
  output logic                 first_err_y
);

  localparam int K     = ceil_div(N, CHUNK);
  localparam int HW_W  = clog2(N + 1);
  localparam int PC_W  = clog2(CHUNK + 1);
  localparam int IDX_W = (K > 1) ? clog2(K) : 1;
  localparam int PAD_W = K * CHUNK;

  localparam logic [HW_W-1:0]  THRESH_V = HW_W'(THRESH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  chk_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [N-1:0]     x_q, x_d;
  logic             y_q, y_d;
  logic [HW_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             res_valid_q, res_valid_d;
  logic             res_mismatch_q, res_mismatch_d;
  logic             res_ref_q, res_ref_d;
  logic [HW_W-1:0]  res_hw_q, res_hw_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             fe_valid_q, fe_valid_d;
  logic [N-1:0]     fe_x_q, fe_x_d;
  logic             fe_y_q, fe_y_d;

  logic [PAD_W-1:0] x_pad;
  logic [CHUNK-1:0] chunk_bits;
  logic [PC_W-1:0]  chunk_cnt;
  logic [HW_W-1:0]  acc_sum;
  logic             sum_ref;
  logic             decided;

  // The final chunk reads zero padding above bit N-1, so it never adds weight.
  always_comb begin
    x_pad          = '0;
    x_pad[N-1:0]   = x_q;
    chunk_bits     = x_pad[int'(idx_q) * CHUNK +: CHUNK];
  end

  maj_chunk_popcount #(
    .CHUNK (CHUNK)
  ) u_popcount (
    .chunk (chunk_bits),
    .count (chunk_cnt)
  );

  assign acc_sum = acc_q + HW_W'(chunk_cnt);
  assign sum_ref = (acc_sum >= THRESH_V);

`ifdef MAJ_CHK_EARLY_EXIT_EN
  int done_bits;
  int rem_bits;

  // Settled once the threshold is met or the unsummed real bits can no longer reach it.
  always_comb begin
    done_bits = (int'(idx_q) + 1) * CHUNK;
    rem_bits  = (done_bits >= N) ? 0 : N - done_bits;
    decided   = (idx_q == LAST_IDX) || sum_ref || ((int'(acc_sum) + rem_bits) < THRESH);
  end
`else
  assign decided = (idx_q == LAST_IDX);
`endif

  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    x_d            = x_q;
    y_d            = y_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    res_valid_d    = 1'b0;
    res_mismatch_d = res_mismatch_q;
    res_ref_d      = res_ref_q;
    res_hw_d       = res_hw_q;
    vec_count_d    = vec_count_q;
    err_count_d    = err_count_q;
    fe_valid_d     = fe_valid_q;
    fe_x_d         = fe_x_q;
    fe_y_d         = fe_y_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          x_d        = bus.in_x;
          y_d        = bus.in_y;
          acc_d      = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = COUNT;
        end
      end
      COUNT: begin
        acc_d = acc_sum;
        idx_d = idx_q + IDX_W'(1);
        if (decided) begin
          state_d        = CMP;
          res_valid_d    = 1'b1;
          res_hw_d       = acc_sum;
          res_ref_d      = sum_ref;
          res_mismatch_d = (y_q != sum_ref);
        end
      end
      CMP: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
        if (vec_count_q != '1) vec_count_d = vec_count_q + CNT_W'(1);
        if (res_mismatch_q) begin
          if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
          if (!fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_x_d     = x_q;
            fe_y_d     = y_q;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase

    // Clearing overrides any same-cycle count or capture but leaves the check itself running.
    if (clr) begin
      vec_count_d = '0;
      err_count_d = '0;
      fe_valid_d  = 1'b0;
      fe_x_d      = '0;
      fe_y_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b1;
      x_q            <= '0;
      y_q            <= 1'b0;
      acc_q          <= '0;
      idx_q          <= '0;
      res_valid_q    <= 1'b0;
      res_mismatch_q <= 1'b0;
      res_ref_q      <= 1'b0;
      res_hw_q       <= '0;
      vec_count_q    <= '0;
      err_count_q    <= '0;
      fe_valid_q     <= 1'b0;
      fe_x_q         <= '0;
      fe_y_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      x_q            <= x_d;
      y_q            <= y_d;
      acc_q          <= acc_d;
      idx_q          <= idx_d;
      res_valid_q    <= res_valid_d;
      res_mismatch_q <= res_mismatch_d;
      res_ref_q      <= res_ref_d;
      res_hw_q       <= res_hw_d;
      vec_count_q    <= vec_count_d;
      err_count_q    <= err_count_d;
      fe_valid_q     <= fe_valid_d;
      fe_x_q         <= fe_x_d;
      fe_y_q         <= fe_y_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_mismatch = res_mismatch_q;
  assign bus.res_ref      = res_ref_q;
  assign bus.res_hw       = res_hw_q;

  assign vec_count        = vec_count_q;
  assign err_count        = err_count_q;
  assign first_err_valid  = fe_valid_q;
  assign first_err_x      = fe_x_q;
  assign first_err_y      = fe_y_q;

endmodule

// File: tb/tb_maj_result_checker.sv
// Directed self-checking bench for maj_result_checker at N=59, CHUNK=8, THRESH=30.
module tb_maj_result_checker;
  import maj_chk_pkg::*;

  localparam int N     = 59;
  localparam int CNT_W = 32;

  localparam logic [N-1:0] X_ZERO = '0;
  localparam logic [N-1:0] X_ALL  = '1;
  localparam logic [N-1:0] X_30   = 59'h3FFFFFFF;
  localparam logic [N-1:0] X_29   = 59'h1FFFFFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_count;
  logic             first_err_valid;
  logic [N-1:0]     first_err_x;
  logic             first_err_y;

  int tests_run    = 0;
  int tests_failed = 0;

  maj_result_checker_if #(.N(N)) bus ();

  maj_result_checker #(
    .N      (N),
    .CHUNK  (8),
    .THRESH (30),
    .CNT_W  (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .clr             (clr),
    .bus             (bus),
    .vec_count       (vec_count),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_x     (first_err_x),
    .first_err_y     (first_err_y)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one vector and returns just after the edge that accepted it.
  task automatic send_vector(input logic [N-1:0] x, input logic y);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Cycle number of the result pulse, counting the accept edge as cycle 0; -1 on timeout.
  task automatic wait_result(output int cyc);
    int ticks;
    ticks = 0;
    do begin
      tick();
      ticks++;
    end while (!bus.res_valid && ticks < 20);
    cyc = bus.res_valid ? ticks + 1 : -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_y = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset.in_ready got=%0b exp=1", bus.in_ready); end
    tests_run++; if (bus.res_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset.res_valid got=%0b exp=0", bus.res_valid); end
    tests_run++; if (bus.res_hw !== 6'd0) begin tests_failed++; $display("[TB] FAIL reset.res_hw got=%0d exp=0", bus.res_hw); end
    tests_run++; if (vec_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset.vec_count got=%0d exp=0", vec_count); end
    tests_run++; if (err_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset.err_count got=%0d exp=0", err_count); end
    tests_run++; if (first_err_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset.first_err_valid got=%0b exp=0", first_err_valid); end
  endtask

  task automatic test_zero_vector;
    int cyc;
    send_vector(X_ZERO, 1'b0);
    wait_result(cyc);
    tests_run++; if (cyc != 9) begin tests_failed++; $display("[TB] FAIL zero.latency got=%0d exp=9", cyc); end
    tests_run++; if (bus.res_hw !== 6'd0) begin tests_failed++; $display("[TB] FAIL zero.res_hw got=%0d exp=0", bus.res_hw); end
    tests_run++; if (bus.res_ref !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero.res_ref got=%0b exp=0", bus.res_ref); end
    tests_run++; if (bus.res_mismatch !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero.res_mismatch got=%0b exp=0", bus.res_mismatch); end
    tick();
    tests_run++; if (bus.res_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero.res_valid_pulse got=%0b exp=0", bus.res_valid); end
    tests_run++; if (vec_count !== 32'd1) begin tests_failed++; $display("[TB] FAIL zero.vec_count got=%0d exp=1", vec_count); end
    tests_run++; if (err_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL zero.err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_thresh_boundary;
    int cyc;
    send_vector(X_30, 1'b0);
    wait_result(cyc);
    tests_run++; if (cyc != 9) begin tests_failed++; $display("[TB] FAIL thresh.latency got=%0d exp=9", cyc); end
    tests_run++; if (bus.res_hw !== 6'd30) begin tests_failed++; $display("[TB] FAIL thresh.res_hw got=%0d exp=30", bus.res_hw); end
    tests_run++; if (bus.res_ref !== 1'b1) begin tests_failed++; $display("[TB] FAIL thresh.res_ref got=%0b exp=1", bus.res_ref); end
    tests_run++; if (bus.res_mismatch !== 1'b1) begin tests_failed++; $display("[TB] FAIL thresh.res_mismatch got=%0b exp=1", bus.res_mismatch); end
    tick();
    tests_run++; if (vec_count !== 32'd2) begin tests_failed++; $display("[TB] FAIL thresh.vec_count got=%0d exp=2", vec_count); end
    tests_run++; if (err_count !== 32'd1) begin tests_failed++; $display("[TB] FAIL thresh.err_count got=%0d exp=1", err_count); end
    tests_run++; if (first_err_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL thresh.first_err_valid got=%0b exp=1", first_err_valid); end
    tests_run++; if (first_err_x !== X_30) begin tests_failed++; $display("[TB] FAIL thresh.first_err_x got=%0h exp=%0h", first_err_x, X_30); end
    tests_run++; if (first_err_y !== 1'b0) begin tests_failed++; $display("[TB] FAIL thresh.first_err_y got=%0b exp=0", first_err_y); end
  endtask

  task automatic test_sticky_first_error;
    int cyc;
    send_vector(X_29, 1'b0);
    wait_result(cyc);
    tests_run++; if (bus.res_hw !== 6'd29) begin tests_failed++; $display("[TB] FAIL below.res_hw got=%0d exp=29", bus.res_hw); end
    tests_run++; if (bus.res_ref !== 1'b0) begin tests_failed++; $display("[TB] FAIL below.res_ref got=%0b exp=0", bus.res_ref); end
    tests_run++; if (bus.res_mismatch !== 1'b0) begin tests_failed++; $display("[TB] FAIL below.res_mismatch got=%0b exp=0", bus.res_mismatch); end
    tick();
    send_vector(X_ALL, 1'b0);
    wait_result(cyc);
    tests_run++; if (cyc != 9) begin tests_failed++; $display("[TB] FAIL allones.latency got=%0d exp=9", cyc); end
    tests_run++; if (bus.res_hw !== 6'd59) begin tests_failed++; $display("[TB] FAIL allones.res_hw got=%0d exp=59", bus.res_hw); end
    tests_run++; if (bus.res_mismatch !== 1'b1) begin tests_failed++; $display("[TB] FAIL allones.res_mismatch got=%0b exp=1", bus.res_mismatch); end
    tick();
    tests_run++; if (vec_count !== 32'd4) begin tests_failed++; $display("[TB] FAIL sticky.vec_count got=%0d exp=4", vec_count); end
    tests_run++; if (err_count !== 32'd2) begin tests_failed++; $display("[TB] FAIL sticky.err_count got=%0d exp=2", err_count); end
    tests_run++; if (first_err_x !== X_30) begin tests_failed++; $display("[TB] FAIL sticky.first_err_x got=%0h exp=%0h", first_err_x, X_30); end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] vx [3];
    logic         vy [3];
    int           acc_cyc [3];
    int           n_acc, n_res, n_low;
    logic         rdy;
    vx = '{X_ZERO, X_ALL, X_30};
    vy = '{1'b0, 1'b1, 1'b1};
    n_acc = 0;
    n_res = 0;
    n_low = 0;
    acc_cyc = '{-100, -100, -100};
    bus.in_x = vx[0];
    bus.in_y = vy[0];
    bus.in_valid = 1'b1;
    for (int c = 0; c < 35; c++) begin
      rdy = bus.in_ready && bus.in_valid;
      tick();
      if (rdy) begin
        if (n_acc < 3) acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc < 3) begin
          bus.in_x = vx[n_acc];
          bus.in_y = vy[n_acc];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (!bus.in_ready) n_low++;
      if (bus.res_valid) n_res++;
    end
    bus.in_valid = 1'b0;
    tests_run++; if (n_acc != 3) begin tests_failed++; $display("[TB] FAIL b2b.accepts got=%0d exp=3", n_acc); end
    tests_run++; if (acc_cyc[1] - acc_cyc[0] != 10) begin tests_failed++; $display("[TB] FAIL b2b.spacing01 got=%0d exp=10", acc_cyc[1] - acc_cyc[0]); end
    tests_run++; if (acc_cyc[2] - acc_cyc[1] != 10) begin tests_failed++; $display("[TB] FAIL b2b.spacing12 got=%0d exp=10", acc_cyc[2] - acc_cyc[1]); end
    tests_run++; if (n_low != 27) begin tests_failed++; $display("[TB] FAIL b2b.ready_low_cycles got=%0d exp=27", n_low); end
    tests_run++; if (n_res != 3) begin tests_failed++; $display("[TB] FAIL b2b.res_pulses got=%0d exp=3", n_res); end
    tests_run++; if (vec_count !== 32'd7) begin tests_failed++; $display("[TB] FAIL b2b.vec_count got=%0d exp=7", vec_count); end
    tests_run++; if (err_count !== 32'd2) begin tests_failed++; $display("[TB] FAIL b2b.err_count got=%0d exp=2", err_count); end
  endtask

  task automatic test_clr;
    int cyc;
    send_vector(X_ALL, 1'b0);
    wait_result(cyc);
    tests_run++; if (bus.res_mismatch !== 1'b1) begin tests_failed++; $display("[TB] FAIL clr_cmp.res_mismatch got=%0b exp=1", bus.res_mismatch); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests_run++; if (vec_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL clr_cmp.vec_count got=%0d exp=0", vec_count); end
    tests_run++; if (err_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL clr_cmp.err_count got=%0d exp=0", err_count); end
    tests_run++; if (first_err_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL clr_cmp.first_err_valid got=%0b exp=0", first_err_valid); end
    tests_run++; if (first_err_x !== X_ZERO) begin tests_failed++; $display("[TB] FAIL clr_cmp.first_err_x got=%0h exp=0", first_err_x); end
    tests_run++; if (bus.res_mismatch !== 1'b1) begin tests_failed++; $display("[TB] FAIL clr_cmp.res_hold got=%0b exp=1", bus.res_mismatch); end
    send_vector(X_30, 1'b1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_result(cyc);
    tests_run++; if (cyc != 7) begin tests_failed++; $display("[TB] FAIL clr_flight.latency got=%0d exp=7", cyc); end
    tests_run++; if (bus.res_hw !== 6'd30) begin tests_failed++; $display("[TB] FAIL clr_flight.res_hw got=%0d exp=30", bus.res_hw); end
    tick();
    tests_run++; if (vec_count !== 32'd1) begin tests_failed++; $display("[TB] FAIL clr_flight.vec_count got=%0d exp=1", vec_count); end
  endtask

  task automatic test_reset_mid_count;
    int n_res;
    send_vector(X_ALL, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort.in_ready got=%0b exp=1", bus.in_ready); end
    tests_run++; if (vec_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL abort.vec_count got=%0d exp=0", vec_count); end
    tests_run++; if (bus.res_hw !== 6'd0) begin tests_failed++; $display("[TB] FAIL abort.res_hw got=%0d exp=0", bus.res_hw); end
    tick();
    rst = 1'b0;
    n_res = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.res_valid) n_res++;
    end
    tests_run++; if (n_res != 0) begin tests_failed++; $display("[TB] FAIL abort.res_pulses got=%0d exp=0", n_res); end
    tests_run++; if (err_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL abort.err_count got=%0d exp=0", err_count); end
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort.in_ready_after got=%0b exp=1", bus.in_ready); end
  endtask

`ifdef MAJ_CHK_EARLY_EXIT_EN
  task automatic test_early_exit;
    int cyc;
    send_vector(X_ALL, 1'b1);
    wait_result(cyc);
    tests_run++; if (cyc != 5) begin tests_failed++; $display("[TB] FAIL early_ones.latency got=%0d exp=5", cyc); end
    tests_run++; if (bus.res_hw !== 6'd32) begin tests_failed++; $display("[TB] FAIL early_ones.res_hw got=%0d exp=32", bus.res_hw); end
    tests_run++; if (bus.res_mismatch !== 1'b0) begin tests_failed++; $display("[TB] FAIL early_ones.res_mismatch got=%0b exp=0", bus.res_mismatch); end
    tick();
    send_vector(X_ZERO, 1'b0);
    wait_result(cyc);
    tests_run++; if (cyc != 5) begin tests_failed++; $display("[TB] FAIL early_zero.latency got=%0d exp=5", cyc); end
    tests_run++; if (bus.res_ref !== 1'b0) begin tests_failed++; $display("[TB] FAIL early_zero.res_ref got=%0b exp=0", bus.res_ref); end
    tick();
    tests_run++; if (vec_count !== 32'd2) begin tests_failed++; $display("[TB] FAIL early.vec_count got=%0d exp=2", vec_count); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef MAJ_CHK_EARLY_EXIT_EN
    test_early_exit();
`else
    test_zero_vector();
    test_thresh_boundary();
    test_sticky_first_error();
    test_back_to_back();
    test_clr();
    test_reset_mid_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
